counter_ctrl: RTL

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/counter_ctrl.sv
// Run/direction controller for an 8-bit up/down counter: debounces two raw
// buttons and keeps the counter bouncing between (or stopping at) 00 and FF.
module counter_ctrl #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter bit          AUTO_REVERSE = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_run_i,
  input  logic       btn_dir_i,
  input  logic [7:0] q_i,
  output logic       e_o,
  output logic       m_o,
  output logic       rev_o
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  // Index 0 is the run button, index 1 the direction button.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      lvl_q, lvl_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      press_q, press_d;

  logic e_q, e_d;
  logic m_q, m_d;
  logic rev_q, rev_d;

  logic up_lim, dn_lim, lim, at_end;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl_d[i]   = lvl_q[i];
      cnt_d[i]   = 8'd0;
      press_d[i] = 1'b0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          lvl_d[i]   = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Limit is detected one value early so the counter's last step lands on FF/00.
  assign up_lim = e_q & m_q & (q_i == 8'hFE);
  assign dn_lim = e_q & ~m_q & (q_i == 8'h01);
  assign lim    = up_lim | dn_lim;
  assign at_end = (m_q & (q_i == 8'hFF)) | (~m_q & (q_i == 8'h00));

  always_comb begin
    e_d   = e_q;
    m_d   = m_q;
    rev_d = 1'b0;
    if (lim) begin
      rev_d = 1'b1;
      if (AUTO_REVERSE) begin
        m_d = ~m_q;
      end else begin
        e_d = 1'b0;
      end
      if (press_q[0]) begin
        e_d = 1'b0;
      end else begin
        e_d = e_d;
      end
    end else begin
      if (press_q[0]) begin
        if (e_q) begin
          e_d = 1'b0;
        end else begin
          e_d = 1'b1;
          if (at_end) begin
            m_d = ~m_q;
          end else begin
            m_d = m_q;
          end
        end
      end else begin
        e_d = e_q;
      end
      m_d = m_d ^ press_q[1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      lvl_q   <= 2'b00;
      cnt_q   <= '0;
      press_q <= 2'b00;
      e_q     <= 1'b0;
      m_q     <= 1'b1;
      rev_q   <= 1'b0;
    end else begin
      sync1_q <= {btn_dir_i, btn_run_i};
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      e_q     <= e_d;
      m_q     <= m_d;
      rev_q   <= rev_d;
    end
  end

  assign e_o   = e_q;
  assign m_o   = m_q;
  assign rev_o = rev_q;

endmodule
